// File: rtl/cache_mem_responder_if.sv
// Cache-bus bundle between the icache/dcache pair and the memory-side responder.
// Request signals flow master->slave; wait/load signals flow back.
interface cache_mem_responder_if;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr,
    input  dload, dwait, iload, iwait
  );

  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr,
    output dload, dwait, iload, iwait
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Word-addressed backing store answering icache/dcache requests after a fixed
// ACCESS latency, using the wait-low one-cycle acknowledge handshake.
module cache_mem_responder #(
  parameter int LAT        = 2,
  parameter int DEPTH_BITS = 10
) (
  input  logic                        CLK,
  input  logic                        nRST,
  cache_mem_responder_if.slave        bus,
  input  logic                        bd_wen,
  input  logic [31:0]                 bd_addr,
  input  logic [31:0]                 bd_data
);

  localparam int WORDS = 1 << DEPTH_BITS;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;
  typedef enum logic {OWN_D, OWN_I} owner_e;
  typedef enum logic {OP_RD, OP_WR} op_e;

  logic [31:0] mem [WORDS];

  state_e      state, state_nxt;
  owner_e      owner, last_owner;
  op_e         op;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  cnt;

  logic        d_req, i_req, grant_d;
  op_e         d_op, own_op;
  logic        own_req, abort, last_cnt;
  logic [31:0] own_addr, rd_word;
  logic [DEPTH_BITS-1:0] idx, bd_idx;
  logic        unused_bd_bits;

  assign idx            = addr_q[DEPTH_BITS+1:2];
  assign bd_idx         = bd_addr[DEPTH_BITS+1:2];
  assign unused_bd_bits = ^{bd_addr[31:DEPTH_BITS+2], bd_addr[1:0]};
  assign last_cnt       = (cnt == 4'(LAT - 1));

  // Request decode, tie arbitration and abort detection for the current owner.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    d_req    = bus.dREN | bus.dWEN;
    i_req    = bus.iREN;
    d_op     = bus.dWEN ? OP_WR : OP_RD;
    grant_d  = d_req && (!i_req || last_owner == OWN_I);
    own_req  = (owner == OWN_D) ? d_req : i_req;
    own_addr = (owner == OWN_D) ? bus.daddr : bus.iaddr;
    own_op   = (owner == OWN_D) ? d_op : OP_RD;
    abort    = !own_req || (own_addr != addr_q) || (own_op != op);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      owner      <= OWN_D;
      op         <= OP_RD;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      last_owner <= OWN_I;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (d_req || i_req) begin
          owner   <= grant_d ? OWN_D : OWN_I;
          op      <= grant_d ? d_op : OP_RD;
          addr_q  <= grant_d ? bus.daddr : bus.iaddr;
          wdata_q <= grant_d ? bus.dstore : '0;
          cnt     <= '0;
        end
        ACCESS: cnt <= cnt + 4'd1;
        ACK:    last_owner <= owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (d_req || i_req) state_nxt = ACCESS;
      ACCESS:  if (abort) state_nxt = IDLE;
               else if (last_cnt) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only the owner sees its wait drop, and only for the single ACK cycle.
  always_comb begin
    bus.dwait = 1'b1;
    bus.iwait = 1'b1;
    bus.dload = '0;
    bus.iload = '0;
    rd_word   = mem[idx];
    if (state == ACK) begin
      if (owner == OWN_D) begin
        bus.dwait = 1'b0;
        if (op == OP_RD) bus.dload = rd_word;
      end else begin
        bus.iwait = 1'b0;
        bus.iload = rd_word;
      end
    end
  end

  // NOTE: the store has no reset; contents survive nRST and are preloaded via the backdoor.
  // The cache write is issued last so it overrides a same-index backdoor write.
  always_ff @(posedge CLK) begin
    if (bd_wen) mem[bd_idx] <= bd_data;
    if (state == ACK && op == OP_WR) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: latency, write/read-back, wrap,
// tie arbitration, abort, async reset and backdoor/cache write collision.
module tb_cache_mem_responder;
  logic        CLK;
  logic        nRST;
  logic        bd_wen;
  logic [31:0] bd_addr, bd_data;
  int          total, bad;
  int          n;

  cache_mem_responder_if bus ();

  cache_mem_responder #(.LAT(2), .DEPTH_BITS(10)) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .bus    (bus),
    .bd_wen (bd_wen),
    .bd_addr(bd_addr),
    .bd_data(bd_data)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Steps until the chosen side's wait drops; returns steps taken, 99 on timeout.
  task automatic wait_ack(input bit is_d, output int cycles);
    cycles = 99;
    for (int k = 1; k <= 20; k++) begin
      step();
      if ((is_d ? bus.dwait : bus.iwait) == 1'b0) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
    bd_wen = 1'b1; bd_addr = a; bd_data = d;
    step();
    bd_wen = 1'b0;
  endtask

  task automatic d_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    int c;
    bus.daddr = a; bus.dREN = 1'b1;
    wait_ack(1'b1, c);
    check({tag, "_lat"}, 32'(c), 32'd3);
    check(tag, bus.dload, exp);
    bus.dREN = 1'b0;
    step();
  endtask

  initial begin
    total = 0; bad = 0;
    nRST = 1'b0;
    bd_wen = 1'b0; bd_addr = '0; bd_data = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.iREN = 1'b0; bus.iaddr = '0;

    // Reset values
    step(); step();
    check("rst_dwait", {31'b0, bus.dwait}, 32'd1);
    check("rst_iwait", {31'b0, bus.iwait}, 32'd1);
    check("rst_dload", bus.dload, 32'h0);
    check("rst_iload", bus.iload, 32'h0);
    nRST = 1'b1;
    step();

    // Basic read: ack exactly at t+3, wait high again at t+4
    bd_write(32'h40, 32'hDEADBEEF);
    bus.daddr = 32'h40; bus.dREN = 1'b1;
    step();
    check("rd_t1_dwait", {31'b0, bus.dwait}, 32'd1);
    check("rd_t1_dload", bus.dload, 32'h0);
    step();
    check("rd_t2_dwait", {31'b0, bus.dwait}, 32'd1);
    step();
    check("rd_t3_dwait", {31'b0, bus.dwait}, 32'd0);
    check("rd_t3_dload", bus.dload, 32'hDEADBEEF);
    check("rd_t3_iwait", {31'b0, bus.iwait}, 32'd1);
    // Request held: IDLE gap at t+4 then re-grant, next ack 4 cycles later
    step();
    check("rd_t4_dwait", {31'b0, bus.dwait}, 32'd1);
    check("rd_t4_dload", bus.dload, 32'h0);
    step(); step(); step();
    check("rd_t7_dwait", {31'b0, bus.dwait}, 32'd0);
    bus.dREN = 1'b0;
    step();

    // Write then read back, plus wrapped alias address
    bus.daddr = 32'h104; bus.dstore = 32'h12345678; bus.dWEN = 1'b1;
    wait_ack(1'b1, n);
    check("wr_lat", 32'(n), 32'd3);
    check("wr_dload", bus.dload, 32'h0);
    bus.dWEN = 1'b0;
    step();
    d_read("rdback", 32'h104, 32'h12345678);
    d_read("rdwrap", 32'h1104, 32'h12345678);

    // Tie arbitration after reset: D first, then I LAT+2 cycles later, twice
    bd_write(32'h300, 32'h11111111);
    nRST = 1'b0; step(); nRST = 1'b1;
    for (int r = 0; r < 2; r++) begin
      bus.daddr = 32'h40; bus.dREN = 1'b1;
      bus.iaddr = 32'h300; bus.iREN = 1'b1;
      wait_ack(1'b1, n);
      check($sformatf("tie%0d_d_lat", r), 32'(n), 32'd3);
      check($sformatf("tie%0d_d_iwait", r), {31'b0, bus.iwait}, 32'd1);
      check($sformatf("tie%0d_dload", r), bus.dload, 32'hDEADBEEF);
      bus.dREN = 1'b0;
      wait_ack(1'b0, n);
      check($sformatf("tie%0d_i_lat", r), 32'(n), 32'd4);
      check($sformatf("tie%0d_iload", r), bus.iload, 32'h11111111);
      check($sformatf("tie%0d_i_dwait", r), {31'b0, bus.dwait}, 32'd1);
      bus.iREN = 1'b0;
      step();
    end

    // Abort: dREN dropped at t+1, pending iREN granted from the IDLE at t+2
    bus.daddr = 32'h40; bus.dREN = 1'b1;
    step();
    bus.dREN = 1'b0; bus.iaddr = 32'h300; bus.iREN = 1'b1;
    step();
    check("abort_t2_dwait", {31'b0, bus.dwait}, 32'd1);
    step(); step(); step();
    check("abort_i_ack", {31'b0, bus.iwait}, 32'd0);
    check("abort_iload", bus.iload, 32'h11111111);
    bus.iREN = 1'b0;
    step();

    // Write aborted by address change: only the new address gets written
    bus.daddr = 32'h40; bus.dstore = 32'hBAD0BAD0; bus.dWEN = 1'b1;
    step();
    bus.daddr = 32'h44;
    wait_ack(1'b1, n);
    check("wabort_lat", 32'(n), 32'd4);
    bus.dWEN = 1'b0;
    step();
    d_read("wabort_old", 32'h40, 32'hDEADBEEF);
    d_read("wabort_new", 32'h44, 32'hBAD0BAD0);

    // Async reset during ACCESS of a write discards it
    bd_write(32'h80, 32'h0);
    bus.daddr = 32'h80; bus.dstore = 32'hCAFEF00D; bus.dWEN = 1'b1;
    step(); step();
    nRST = 1'b0;
    #1;
    check("mid_rst_dwait", {31'b0, bus.dwait}, 32'd1);
    check("mid_rst_iwait", {31'b0, bus.iwait}, 32'd1);
    check("mid_rst_dload", bus.dload, 32'h0);
    bus.dWEN = 1'b0;
    step();
    nRST = 1'b1;
    step();
    d_read("rst_discard", 32'h80, 32'h0);

    // dREN&&dWEN is a write; same-cycle backdoor write loses to it
    bus.daddr = 32'h200; bus.dstore = 32'hA5A5A5A5;
    bus.dREN = 1'b1; bus.dWEN = 1'b1;
    wait_ack(1'b1, n);
    check("rw_lat", 32'(n), 32'd3);
    check("rw_dload", bus.dload, 32'h0);
    bd_wen = 1'b1; bd_addr = 32'h200; bd_data = 32'h77777777;
    bus.dREN = 1'b0; bus.dWEN = 1'b0;
    step();
    bd_wen = 1'b0;
    step();
    d_read("rw_rdback", 32'h200, 32'hA5A5A5A5);

    // Last owner was D, so a tie now goes to I first
    bus.daddr = 32'h200; bus.dREN = 1'b1;
    bus.iaddr = 32'h300; bus.iREN = 1'b1;
    wait_ack(1'b0, n);
    check("tie3_i_lat", 32'(n), 32'd3);
    check("tie3_i_dwait", {31'b0, bus.dwait}, 32'd1);
    bus.iREN = 1'b0;
    wait_ack(1'b1, n);
    check("tie3_d_lat", 32'(n), 32'd4);
    check("tie3_dload", bus.dload, 32'hA5A5A5A5);
    bus.dREN = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
